// File: rtl/gcd_stein_core.sv
// Binary (Stein) GCD engine: shift/subtract only, one step per clock.
// Latency: 2 cycles for a zero operand, otherwise at most 4*GCDw+4 cycles.
// Backpressure: none; start is honoured only in IDLE/DONE, otherwise dropped.
// Optional: define GCD_STEIN_CYCLE_CNT_EN to add the `cycles` latency counter port.
module gcd_stein_core #(
    parameter int GCDw = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [GCDw-1:0] in1,
    input  logic [GCDw-1:0] in2,
    output logic            busy,
    output logic            done,
    output logic [GCDw-1:0] gcd
`ifdef GCD_STEIN_CYCLE_CNT_EN
    ,
    output logic [GCDw-1:0] cycles
`endif
);

    localparam int KW = $clog2(GCDw) + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STRIP  = 3'd1,
        REDUCE = 3'd2,
        SCALE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [GCDw-1:0] a, a_nxt;
    logic [GCDw-1:0] b, b_nxt;
    logic [KW-1:0]   k, k_nxt;
    logic [GCDw-1:0] gcd_nxt;
    logic            busy_nxt;
    logic            done_nxt;
    logic            accept;

    // A request is taken only when no computation is in flight.
    assign accept = start && ((state == IDLE) || (state == DONE));

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            k     <= '0;
            gcd   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            a     <= a_nxt;
            b     <= b_nxt;
            k     <= k_nxt;
            gcd   <= gcd_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state and datapath step: exactly one action per state per cycle.
    always_comb begin
        state_nxt = state;
        a_nxt     = a;
        b_nxt     = b;
        k_nxt     = k;
        gcd_nxt   = gcd;
        busy_nxt  = busy;
        done_nxt  = done;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    a_nxt    = in1;
                    b_nxt    = in2;
                    k_nxt    = '0;
                    busy_nxt = 1'b1;
                    done_nxt = 1'b0;
                    if ((in1 == '0) || (in2 == '0)) begin
                        // gcd(0,x)=x and gcd(0,0)=0: the OR is the answer, k stays 0.
                        a_nxt     = in1 | in2;
                        state_nxt = SCALE;
                    end else begin
                        state_nxt = STRIP;
                    end
                end
            end
            STRIP: begin
                // Pull out the common power of two; it is restored in SCALE.
                if (!a[0] && !b[0]) begin
                    a_nxt = a >> 1;
                    b_nxt = b >> 1;
                    k_nxt = k + KW'(1);
                end else begin
                    state_nxt = REDUCE;
                end
            end
            REDUCE: begin
                if (!a[0]) begin
                    a_nxt = a >> 1;
                end else if (!b[0]) begin
                    b_nxt = b >> 1;
                end else if (a == b) begin
                    state_nxt = SCALE;
                end else if (a > b) begin
                    a_nxt = a - b;
                end else begin
                    b_nxt = b - a;
                end
            end
            SCALE: begin
                // Cannot overflow: result never exceeds the smaller nonzero operand.
                gcd_nxt   = a << k;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef GCD_STEIN_CYCLE_CNT_EN
    // Latency counter: cleared on accept, counts every busy edge, frozen in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles <= '0;
        end else if (accept) begin
            cycles <= '0;
        end else if (busy) begin
            cycles <= cycles + GCDw'(1);
        end
    end
`endif

endmodule

// File: tb/tb_gcd_stein_core.sv
// Directed + random bench for gcd_stein_core against a Euclid reference model.
// Compare process checks busy/done exclusivity each cycle and result/latency on done rise.
// Driver waits on done with a bounded cycle budget.
module tb_gcd_stein_core;

    localparam int W     = 32;
    localparam int BOUND = 4 * W + 4;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  in1   = '0;
    logic [W-1:0]  in2   = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  gcd;
`ifdef GCD_STEIN_CYCLE_CNT_EN
    logic [W-1:0]  cycles;
`endif

    int tests = 0;
    int fails = 0;

    int           edge_cnt    = 0;
    int           accept_edge = 0;
    bit           armed       = 1'b0;
    logic [W-1:0] exp_gcd     = '0;
    logic         done_q      = 1'b0;

    gcd_stein_core #(.GCDw(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .gcd   (gcd)
`ifdef GCD_STEIN_CYCLE_CNT_EN
        ,
        .cycles(cycles)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    // Reference: plain Euclid, independent of the shift/subtract formulation.
    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle compare process.
    always @(negedge clk) begin
        if (reset) begin
            tests++;
            if (busy && done) begin
                fails++;
                $display("FAIL busy_done_overlap: busy=%0b done=%0b, required not both high", busy, done);
            end
            if (armed && done && !done_q) begin
                armed = 1'b0;
                check("model_gcd", gcd, exp_gcd);
                tests++;
                if (edge_cnt - accept_edge > BOUND) begin
                    fails++;
                    $display("FAIL latency_bound: got %0d edges, required <= %0d", edge_cnt - accept_edge, BOUND);
                end
`ifdef GCD_STEIN_CYCLE_CNT_EN
                check("cycles_vs_latency", cycles, W'(edge_cnt - accept_edge));
`endif
            end
        end
        done_q = done;
    end

    // Present operands for one edge; arm the model expectation.
    task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        in1         = x;
        in2         = y;
        start       = 1'b1;
        exp_gcd     = ref_gcd(x, y);
        accept_edge = edge_cnt + 1;
        armed       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Operands must not be re-read after accept.
        in1 = $urandom;
        in2 = $urandom;
        check("busy_after_accept", W'(busy), W'(1));
        check("done_after_accept", W'(done), W'(0));
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < BOUND + 8) begin
            @(negedge clk);
            n++;
        end
        check(name, W'(done), W'(1));
    endtask

    task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] lit, input string name);
        do_start(x, y);
        wait_done({name, "_done"});
        check(name, gcd, lit);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_busy", W'(busy), W'(0));
        check("reset_done", W'(done), W'(0));
        check("reset_gcd",  gcd,      W'(0));
        reset = 1'b1;

        // Basic (12,18): done after N+7, one cycle later busy low.
        do_start(32'd12, 32'd18);
        wait_done("basic_done");
        check("basic_gcd", gcd, 32'd6);
        check("basic_latency", W'(edge_cnt - accept_edge), W'(7));
`ifdef GCD_STEIN_CYCLE_CNT_EN
        check("basic_cycles", cycles, 32'd7);
`endif
        @(negedge clk);
        check("basic_busy_after_done", W'(busy), W'(0));
        check("basic_done_held", W'(done), W'(1));

        // Reset in the middle of a computation.
        do_start(32'd12, 32'd18);
        repeat (3) @(posedge clk);
        #1;
        armed = 1'b0;
        reset = 1'b0;
        #1;
        check("midreset_busy", W'(busy), W'(0));
        check("midreset_done", W'(done), W'(0));
        check("midreset_gcd",  gcd,      W'(0));
        @(negedge clk);
        reset = 1'b1;
        run(32'd12, 32'd18, 32'd6, "after_reset");

        // Zero operands.
        do_start(32'd0, 32'd7);
        wait_done("zero07_done");
        check("zero07_gcd", gcd, 32'd7);
        tests++;
        if (edge_cnt - accept_edge > 2) begin
            fails++;
            $display("FAIL zero07_latency: got %0d edges, required <= 2", edge_cnt - accept_edge);
        end
        run(32'd0, 32'd0, 32'd0, "zero00");
        run(32'd5, 32'd0, 32'd5, "zero50");

        // Extremes.
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "all_ones");
        run(32'h8000_0000, 32'h4000_0000, 32'h4000_0000, "pow2");
        run(32'd1, 32'hFFFF_FFFF, 32'd1, "one_allones");
        run(32'd1071, 32'd462, 32'd21, "euclid_classic");
        run(32'd96, 32'd64, 32'd32, "shared_pow2");

        // Start while busy is ignored, then honoured from DONE.
        do_start(32'd48, 32'd36);
        @(negedge clk);
        @(negedge clk);
        in1   = 32'd7;
        in2   = 32'd14;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignored_done");
        check("ignored_gcd", gcd, 32'd12);
        run(32'd7, 32'd14, 32'd7, "restart");

        // Random pairs including 0 and all-ones.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       x = '0;
                1:       x = '1;
                default: x = $urandom >> $urandom_range(0, 31);
            endcase
            case ($urandom_range(0, 9))
                0:       y = '0;
                1:       y = '1;
                2:       y = x << $urandom_range(0, 3);
                default: y = $urandom >> $urandom_range(0, 31);
            endcase
            do_start(x, y);
            wait_done("random_done");
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
